// File: rtl/debug_uart_arbiter_pkg.sv
// debug_uart_arbiter_pkg: shared constants and FSM state type for the debug UART arbiter
// Exports: SRC_ID_W (source id width), MAGIC1_DEF/MAGIC2_DEF (header defaults), state_t
package debug_uart_arbiter_pkg;
    localparam int SRC_ID_W = 3;
    localparam logic [7:0] MAGIC1_DEF = 8'hBE;
    localparam logic [7:0] MAGIC2_DEF = 8'hEF;
    typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR_ID, PAYLOAD} state_t;
endpackage

// File: rtl/debug_uart_arbiter_if.sv
// debug_uart_arbiter_if: source-side, uart_tx-side and status signals of the arbiter
// s_valid/s_data/s_last/s_ready  per-source byte stream (source i at bit i / byte i)
// tx_data/tx_valid/tx_ack        byte link to uart_tx
// busy/grant_id/err_timeout      status
// slave = arbiter view, master = producers + uart_tx view
interface debug_uart_arbiter_if #(parameter int N_SRC = 4);
    import debug_uart_arbiter_pkg::*;
    logic [N_SRC-1:0]    s_valid;
    logic [8*N_SRC-1:0]  s_data;
    logic [N_SRC-1:0]    s_last;
    logic [N_SRC-1:0]    s_ready;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ack;
    logic                busy;
    logic [SRC_ID_W-1:0] grant_id;
    logic                err_timeout;
    modport slave (
        input  s_valid, s_data, s_last, tx_ack,
        output s_ready, tx_data, tx_valid, busy, grant_id, err_timeout
    );
    modport master (
        output s_valid, s_data, s_last, tx_ack,
        input  s_ready, tx_data, tx_valid, busy, grant_id, err_timeout
    );
endinterface

// File: rtl/debug_uart_arbiter_rr.sv
// debug_uart_arbiter_rr: combinational round-robin pick of the first requester after a registered pointer
// clk, rst           clock, sync active-high reset (pointer -> N-1 so source 0 wins first)
// req_i              request vector
// upd_i, upd_ptr_i   load upd_ptr_i into the pointer
// grant_o, any_o     winning index, any request present
module debug_uart_arbiter_rr
    import debug_uart_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_i,
    input  logic                upd_i,
    input  logic [SRC_ID_W-1:0] upd_ptr_i,
    output logic [SRC_ID_W-1:0] grant_o,
    output logic                any_o
);
    logic [SRC_ID_W-1:0] ptr_q;
    logic [N-1:0] rot;
    int off, idx;
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= SRC_ID_W'(N - 1);
        else if (upd_i) ptr_q <= upd_ptr_i;
    end
    // rotate so bit 0 is the source just after the pointer, then take the lowest set bit
    always_comb begin
        rot = N'({req_i, req_i} >> (int'(ptr_q) + 1));
        off = 0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) off = i;
        idx = int'(ptr_q) + 1 + off;
        idx = idx >= N ? idx - N : idx;
        grant_o = SRC_ID_W'(idx);
    end
    assign any_o = |req_i;
endmodule

// File: rtl/debug_uart_arbiter.sv
// debug_uart_arbiter: packet-granular round-robin sharing of one uart_tx, each packet prefixed MAGIC1 MAGIC2 id
// clk, rst  system clock, synchronous active-high reset
// bus       slave modport: source streams in, byte link to uart_tx, busy/grant_id/err_timeout status
module debug_uart_arbiter
    import debug_uart_arbiter_pkg::*;
#(
    parameter int         N_SRC   = 4,
    parameter logic [7:0] MAGIC1  = MAGIC1_DEF,
    parameter logic [7:0] MAGIC2  = MAGIC2_DEF,
    parameter int         TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    debug_uart_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    state_t state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d, sel_data;
    logic tx_valid_q, tx_valid_d, last_q, last_d, err_q, err_d;
    logic [SRC_ID_W-1:0] gid_q, gid_d, arb_gnt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic arb_any, rr_upd, sel_valid, sel_last, take;
    debug_uart_arbiter_rr #(.N(N_SRC)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (bus.s_valid),
        .upd_i     (rr_upd),
        .upd_ptr_i (gid_q),
        .grant_o   (arb_gnt),
        .any_o     (arb_any)
    );
    assign sel_valid = 1'(bus.s_valid >> gid_q);
    assign sel_last  = 1'(bus.s_last >> gid_q);
    assign sel_data  = 8'(bus.s_data >> {gid_q, 3'b000});
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            gid_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
            gid_q      <= gid_d;
            cnt_q      <= cnt_d;
        end
    end
    // holding register empties the cycle after tx_ack; a new byte is only loaded while it is empty
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q && !bus.tx_ack;
        last_d     = last_q;
        gid_d      = gid_q;
        cnt_d      = '0;
        err_d      = 1'b0;
        rr_upd     = 1'b0;
        take       = 1'b0;
        case (state_q)
            IDLE: if (arb_any) begin
                gid_d      = arb_gnt;
                tx_data_d  = MAGIC1;
                tx_valid_d = 1'b1;
                last_d     = 1'b0;
                state_d    = HDR1;
            end
            HDR1, HDR2, HDR_ID: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = state_q == HDR2 ? MAGIC2 : 8'(gid_q);
                end
                if (tx_valid_q && bus.tx_ack)
                    state_d = state_q == HDR1 ? HDR2 : state_q == HDR2 ? HDR_ID : PAYLOAD;
            end
            PAYLOAD: begin
                take = !tx_valid_q && sel_valid;
                if (take) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = sel_data;
                    last_d     = sel_last;
                end
                if (tx_valid_q && bus.tx_ack && last_q) begin
                    state_d = IDLE;
                    rr_upd  = 1'b1;
                end
                // empty register with the granted source silent: count towards abort
                if (!tx_valid_q && !sel_valid) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        rr_upd  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.s_ready     = (take && !rst) ? N_SRC'(1) << gid_q : '0;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.busy        = state_q != IDLE;
    assign bus.grant_id    = gid_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_debug_uart_arbiter.sv
// tb_debug_uart_arbiter: randomized scoreboard bench for debug_uart_arbiter with a uart_tx ack model
module tb_debug_uart_arbiter;
    import debug_uart_arbiter_pkg::*;
    localparam int N  = 4;
    localparam int TO = 1024;
    typedef struct packed {logic [7:0] d; logic first; logic last;} beat_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    debug_uart_arbiter_if #(.N_SRC(N)) bus ();
    debug_uart_arbiter #(.N_SRC(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
    beat_t bq[N][$];
    logic [7:0] exq[$];
    int n_chk = 0, n_pass = 0;
    int rdy_cnt[N], exp_rdy[N];
    int err_cnt = 0, pkt_acks = 0, acnt = 0, mptr = N - 1, maxgap = 3;
    bit flush = 1'b0, inflight = 1'b0;
    logic [7:0] held = '0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add_byte(input int s, input logic [7:0] d, input bit f, input bit l);
        bq[s].push_back('{d: d, first: f, last: l});
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int k = 0; k < len; k++) add_byte(s, 8'($urandom), k == 0, k == len - 1);
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // reference: every source with a queued packet is requesting; whole packets go round-robin
    function automatic int build_expected();
        int pos[N];
        int p = mptr;
        bit any;
        for (int i = 0; i < N; i++) begin pos[i] = 0; exp_rdy[i] = 0; rdy_cnt[i] = 0; end
        err_cnt = 0;
        do begin
            any = 1'b0;
            for (int k = 1; k <= N && !any; k++) begin
                int s = (p + k) % N;
                if (pos[s] < bq[s].size()) begin
                    any = 1'b1;
                    p = s;
                    exq.push_back(8'hBE);
                    exq.push_back(8'hEF);
                    exq.push_back(8'(s));
                    while (pos[s] < bq[s].size()) begin
                        exq.push_back(bq[s][pos[s]].d);
                        exp_rdy[s]++;
                        pos[s]++;
                        if (bq[s][pos[s] - 1].last) break;
                    end
                end
            end
        end while (any);
        mptr = p;
        return p;
    endfunction

    task automatic run_phase(input string nm);
        int g = build_expected();
        int cyc = 0;
        while (!(exq.size() == 0 && !bus.busy && all_empty()) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_completes"}, cyc < 20000, 1);
        chk({nm, "_busy_low"}, bus.busy, 0);
        chk({nm, "_grant_id"}, bus.grant_id, g);
        chk({nm, "_no_timeout"}, err_cnt, 0);
        for (int i = 0; i < N; i++) chk({nm, "_ready_pulses"}, rdy_cnt[i], exp_rdy[i]);
    endtask

    // source drivers: present queued bytes, pop after acceptance, random gaps inside a packet only
    initial begin : drv
        int gap[N];
        bit acc[N];
        bus.s_valid = '0;
        bus.s_data  = '0;
        bus.s_last  = '0;
        for (int i = 0; i < N; i++) begin gap[i] = 0; acc[i] = 1'b0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (flush) begin bq[i].delete(); acc[i] = 1'b0; gap[i] = 0; end
                if (acc[i] && bq[i].size() > 0) begin
                    void'(bq[i].pop_front());
                    gap[i] = (bq[i].size() > 0 && !bq[i][0].first) ? int'($urandom_range(maxgap, 0)) : 0;
                end
                acc[i] = 1'b0;
                if (gap[i] > 0) begin
                    gap[i]--;
                    bus.s_valid[i] = 1'b0;
                end else bus.s_valid[i] = bq[i].size() > 0;
                if (bus.s_valid[i]) begin
                    bus.s_data[8*i +: 8] = bq[i][0].d;
                    bus.s_last[i] = bq[i][0].last;
                end
            end
            #1;
            for (int i = 0; i < N; i++) acc[i] = bus.s_valid[i] && bus.s_ready[i];
        end
    end

    // uart_tx model (ack 10 cycles after valid rises) plus output monitor and scoreboard
    initial begin : mon
        bus.tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.tx_ack = 1'b0;
                inflight = 1'b0;
                acnt = 0;
                pkt_acks = 0;
            end else begin
                if (bus.s_ready != '0)
                    chk("s_ready_owner", bus.s_ready,
                        (bus.busy && pkt_acks >= 3 && !bus.tx_valid) ? (N'(1) << bus.grant_id) : N'(0));
                for (int i = 0; i < N; i++) rdy_cnt[i] += int'(bus.s_ready[i]);
                if (bus.err_timeout) err_cnt++;
                if (!bus.busy) pkt_acks = 0;
                if (bus.tx_ack) begin
                    bus.tx_ack = 1'b0;
                    inflight = 1'b0;
                    chk("tx_valid_clears_after_ack", bus.tx_valid, 0);
                end else if (bus.tx_valid) begin
                    if (!inflight) begin
                        inflight = 1'b1;
                        held = bus.tx_data;
                        acnt = 0;
                    end else chk("tx_data_stable", bus.tx_data, held);
                    acnt++;
                    if (acnt == 10) begin
                        bus.tx_ack = 1'b1;
                        pkt_acks++;
                        chk("scoreboard_has_byte", exq.size() > 0, 1);
                        if (exq.size() > 0) chk("tx_byte", bus.tx_data, exq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : main
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        rst = 1'b0;
        add_byte(1, 8'h12, 1'b1, 1'b0);
        add_byte(1, 8'h34, 1'b0, 1'b1);
        run_phase("src1_two_bytes");
        @(negedge clk); rst = 1'b1; flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0; exq.delete(); mptr = N - 1; rst = 1'b0;
        add_pkt(0, 3);
        add_pkt(2, 2);
        run_phase("src0_src2");
        for (int k = 0; k < 3; k++) add_pkt(3, int'($urandom_range(3, 1)));
        for (int k = 0; k < 2; k++) add_pkt(1, int'($urandom_range(3, 1)));
        run_phase("alternate_3_1");
        for (int r = 0; r < 6; r++) begin
            for (int s = 0; s < N; s++)
                for (int k = int'($urandom_range(2, 0)); k > 0; k--) add_pkt(s, int'($urandom_range(5, 1)));
            if (all_empty()) add_pkt(int'($urandom_range(N - 1, 0)), 1);
            run_phase("random");
        end
        add_byte(0, 8'h5A, 1'b1, 1'b0);
        void'(build_expected());
        cyc = 0;
        while (!(exq.size() == 0 && !bus.tx_valid) && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("timeout_hdr_sent", cyc < 2000, 1);
        cyc = 0;
        while (!bus.err_timeout && cyc < TO + 100) begin @(negedge clk); cyc++; end
        chk("timeout_latency", cyc, TO);
        @(negedge clk);
        chk("timeout_pulse_width", bus.err_timeout, 0);
        chk("timeout_idle", bus.busy, 0);
        chk("timeout_err_count", err_cnt, 1);
        add_pkt(2, 6);
        void'(build_expected());
        cyc = 0;
        while (rdy_cnt[2] < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("midpkt_reached_payload", cyc < 2000, 1);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("midpkt_rst_tx_valid", bus.tx_valid, 0);
        chk("midpkt_rst_busy", bus.busy, 0);
        chk("midpkt_rst_s_ready", bus.s_ready, 0);
        @(negedge clk);
        flush = 1'b0; exq.delete(); mptr = N - 1; rst = 1'b0;
        add_pkt(1, 2);
        add_pkt(0, 2);
        run_phase("after_reset");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
